// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for the alu_seq execute unit.
interface alu_seq_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        operation;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              br_true;
    logic              op_illegal;

    modport master (
        output in_valid, operation, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, br_true, op_illegal
    );

    modport slave (
        input  in_valid, operation, src_a, src_b, out_ready,
        output in_ready, out_valid, result, br_true, op_illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic/branch ops and
// bit-serial shifts (one position per cycle), with a registered result stage.
module alu_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SH_W   = 5
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);

    localparam logic [3:0] OpAnd = 4'h0;
    localparam logic [3:0] OpOr  = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSll = 4'h3;
    localparam logic [3:0] OpSrl = 4'h4;
    localparam logic [3:0] OpSub = 4'h5;
    localparam logic [3:0] OpSra = 4'h6;
    localparam logic [3:0] OpSlt = 4'h7;
    localparam logic [3:0] OpBeq = 4'h8;
    localparam logic [3:0] OpBne = 4'h9;
    localparam logic [3:0] OpBlt = 4'hA;
    localparam logic [3:0] OpBge = 4'hB;
    localparam logic [3:0] OpXor = 4'hC;
    localparam logic [3:0] OpLui = 4'hD;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              br_q, br_d;
    logic              ill_q, ill_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;

    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] diff;
    logic              lt;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] calc_res;
    logic              calc_br;
    logic              calc_ill;
    logic              is_shift;

    // Combinational evaluation of the incoming request.
    always_comb begin
        diff     = bus.src_a - bus.src_b;
        lt       = $signed(bus.src_a) < $signed(bus.src_b);
        shamt    = bus.src_b[SH_W-1:0];
        calc_res = '0;
        calc_br  = 1'b0;
        calc_ill = 1'b0;
        is_shift = 1'b0;
        case (bus.operation)
            OpAnd: calc_res = bus.src_a & bus.src_b;
            OpOr:  calc_res = bus.src_a | bus.src_b;
            OpAdd: calc_res = bus.src_a + bus.src_b;
            OpSub: calc_res = diff;
            OpXor: calc_res = bus.src_a ^ bus.src_b;
            OpLui: calc_res = bus.src_b;
            OpSlt: calc_res = {{(DATA_W-1){1'b0}}, lt};
            OpSll, OpSrl, OpSra: begin
                calc_res = bus.src_a;
                is_shift = 1'b1;
            end
            OpBeq: begin calc_res = diff; calc_br = (diff == '0); end
            OpBne: begin calc_res = diff; calc_br = (diff != '0); end
            OpBlt: begin calc_res = diff; calc_br = lt;           end
            OpBge: begin calc_res = diff; calc_br = !lt;          end
            default: calc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        br_d     = br_q;
        ill_d    = ill_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
        accept   = bus.in_valid && in_ready;

        case (state_q)
            StShift: begin
                case (op_q)
                    OpSll:   res_d = {res_q[DATA_W-2:0], 1'b0};
                    OpSrl:   res_d = {1'b0, res_q[DATA_W-1:1]};
                    default: res_d = {res_q[DATA_W-1], res_q[DATA_W-1:1]};
                endcase
                cnt_d = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) state_d = StDone;
            end
            StDone: if (bus.out_ready) state_d = StIdle;
            default: ;
        endcase

        // An accept in DONE retires the old result and loads the new one.
        if (accept) begin
            op_d  = bus.operation;
            br_d  = calc_br;
            ill_d = calc_ill;
            if (is_shift && (shamt != '0)) begin
                state_d = StShift;
                res_d   = bus.src_a;
                cnt_d   = shamt;
            end else begin
                state_d = StDone;
                res_d   = calc_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            res_q   <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.result     = res_q;
    assign bus.br_true    = br_q;
    assign bus.op_illegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, streaming,
// back-pressure and mid-shift reset sequences, then random ops vs a model.
module tb_alu_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_seq_if #(.DATA_W(32)) bus ();

    alu_seq #(.DATA_W(32), .SH_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: direct arithmetic on whole values.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic br, output logic ill,
                         output int lat);
        int sh;
        sh  = int'(b % 32);
        r   = 0;
        br  = 0;
        ill = 0;
        lat = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  begin r = a << sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd4:  begin r = a >> sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd5:  r = a - b;
            4'd6:  begin r = $signed(a) >>> sh; lat = (sh == 0) ? 1 : sh + 1; end
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  begin r = a - b; br = (a == b); end
            4'd9:  begin r = a - b; br = (a != b); end
            4'd10: begin r = a - b; br = ($signed(a) < $signed(b)); end
            4'd11: begin r = a - b; br = ($signed(a) >= $signed(b)); end
            4'd12: r = a ^ b;
            4'd13: r = b;
            default: ill = 1;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eb, input logic ei, input int el,
                          input string tag);
        bit acc;
        bit rdy_bad;
        int lat;
        int n;
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            check({tag, " accept timeout"}, 32'd0, 32'd1);
            return;
        end
        lat     = 1;
        rdy_bad = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_bad = 1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, el);
        check({tag, " result"}, bus.result, er);
        check({tag, " br_true"}, {31'd0, bus.br_true}, {31'd0, eb});
        check({tag, " op_illegal"}, {31'd0, bus.op_illegal}, {31'd0, ei});
        if (el > 1) check({tag, " in_ready during shift"}, {31'd0, rdy_bad}, 32'd0);
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(posedge clk);
            #1;
            check({tag, " stall result"}, bus.result, er);
            check({tag, " stall in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " retire"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] er;
        logic        eb;
        logic        ei;
        int          el;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        bit          seen;

        vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'h6, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[2]  = '{4'hA, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b1, 1'b0, 1};
        vecs[3]  = '{4'hB, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'h7, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'hF, 32'h12345678, 32'h9,        32'h00000000, 1'b0, 1'b1, 1};
        vecs[6]  = '{4'h2, 32'h1,        32'h2,        32'h00000003, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'h3, 32'h1,        32'd4,        32'h00000010, 1'b0, 1'b0, 5};
        vecs[8]  = '{4'h4, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5};
        vecs[9]  = '{4'h6, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5};
        vecs[10] = '{4'h3, 32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 1'b0, 1'b0, 1};
        vecs[11] = '{4'h8, 32'h7,        32'h7,        32'h00000000, 1'b1, 1'b0, 1};
        vecs[12] = '{4'h9, 32'h7,        32'h7,        32'h00000000, 1'b0, 1'b0, 1};
        vecs[13] = '{4'h0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1};
        vecs[14] = '{4'h1, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1};
        vecs[15] = '{4'hE, 32'h1,        32'h1,        32'h00000000, 1'b0, 1'b1, 1};
        vecs[16] = '{4'h5, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0, 1};
        vecs[17] = '{4'hC, 32'h5,        32'h3,        32'h00000006, 1'b0, 1'b0, 1};
        vecs[18] = '{4'hD, 32'h0,        32'h12345000, 32'h12345000, 1'b0, 1'b0, 1};
        vecs[19] = '{4'h3, 32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0, 32};

        bus.in_valid  = 1'b0;
        bus.operation = 4'h0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset br_true", {31'd0, bus.br_true}, 32'd0);
        check("reset op_illegal", {31'd0, bus.op_illegal}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].br, vecs[i].ill,
                   vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Streaming: back-to-back accepts with out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.operation = 4'hC; bus.src_a = 32'h5; bus.src_b = 32'h3;
        @(posedge clk); #1;
        check("stream xor valid", {31'd0, bus.out_valid}, 32'd1);
        check("stream xor", bus.result, 32'h6);
        bus.operation = 4'h5; bus.src_a = 32'h5; bus.src_b = 32'h7;
        @(posedge clk); #1;
        check("stream sub valid", {31'd0, bus.out_valid}, 32'd1);
        check("stream sub", bus.result, 32'hFFFFFFFE);
        bus.operation = 4'hD; bus.src_a = 32'h0; bus.src_b = 32'h12345000;
        @(posedge clk); #1;
        check("stream lui valid", {31'd0, bus.out_valid}, 32'd1);
        check("stream lui", bus.result, 32'h12345000);
        // Back-pressure: a pending request must be ignored and the result held.
        bus.out_ready = 1'b0;
        bus.operation = 4'h2; bus.src_a = 32'h1; bus.src_b = 32'h1;
        held = bus.result;
        repeat (3) begin
            #1;
            check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
            check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp result", bus.result, 32'h12345000);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp retire", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Reset asserted in the 4th cycle of a 10-position shift.
        bus.operation = 4'h3; bus.src_a = 32'h1; bus.src_b = 32'd10;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-shift rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid-shift rst result", bus.result, 32'd0);
        check("mid-shift rst br_true", {31'd0, bus.br_true}, 32'd0);
        check("mid-shift rst op_illegal", {31'd0, bus.op_illegal}, 32'd0);
        check("mid-shift rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        check("no result after reset", {31'd0, seen}, 32'd0);
        bus.out_ready = 1'b0;
        run_op(4'h2, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1, "post-reset add");

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (($urandom & 3) == 0) b = a;
            model(op, a, b, er, eb, ei, el);
            run_op(op, a, b, er, eb, ei, el, $sformatf("rnd%0d op%0h", i, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle 32-bit execute unit that consumes the 4-bit ALU operation code produced by the ALU controller. Operands and the operation code enter through a valid/ready handshake, and results leave through a registered valid/ready output together with a branch-condition flag. Logic and arithmetic operations complete in one cycle. Shifts are iterated one bit position per cycle, so no barrel shifter is needed. The block sits in the execute stage between the operand muxes and the writeback/branch logic.

## Interface
- DATA_W, 32, operand/result width
- SH_W, 5, shift-amount width; equals log2(DATA_W)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- operation  in  4  ALU operation code
- src_a  in  DATA_W  operand A
- src_b  in  DATA_W  operand B; the shift amount is src_b[SH_W-1:0]
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- result  out  DATA_W  registered result
- br_true  out  1  branch condition met; 0 for non-branch ops
- op_illegal  out  1  opcode 1110 or 1111 was received

## Operation
- Opcode map:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 SLL
  - 0100 SRL
  - 0101 SUB
  - 0110 SRA
  - 0111 SLT (signed; result 1 or 0)
  - 1000 BEQ
  - 1001 BNE
  - 1010 BLT (signed)
  - 1011 BGE (signed)
  - 1100 XOR
  - 1101 LUI (result = src_b)
- Branch ops: result = src_a - src_b; br_true = the comparison outcome.
- Arithmetic is modulo 2^DATA_W, and overflow is ignored. SLT, BLT and BGE compare as two's complement.
- An accept happens on a cycle with in_valid && in_ready. operation, src_a and src_b are captured at that edge.
- States:
  - IDLE: in_ready = 1.
    - Accept of a non-shift op, a shift with shamt 0, or an illegal op → DONE, with result computed.
    - Accept of a shift with shamt ≠ 0 → SHIFT, with the working register = src_a and the counter = shamt.
  - SHIFT: in_ready = 0.
    - Each cycle, shift the working register by 1: SLL fills 0 at bit 0; SRL fills 0 at the MSB; SRA replicates the MSB.
    - The counter decrements each cycle. The transition from counter 1 → DONE is the final shift.
  - DONE: out_valid = 1, and result, br_true and op_illegal are held stable.
    - out_ready = 1 → retire.
    - out_ready = 1 && in_valid → back-to-back accept. in_ready = out_ready in DONE, and the next state follows the IDLE rules.
    - out_ready = 1 && !in_valid → IDLE.
    - out_ready = 0 → stay in DONE.
- Illegal opcode: result = 0, br_true = 0, op_illegal = 1, latency as for a single-cycle op.
- op_illegal and br_true are valid only while out_valid = 1, and they update only on accept/completion.
- Inputs are ignored while in_ready = 0. in_valid may stay high without causing a duplicate accept.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT):
  - state = IDLE
  - out_valid = 0
  - result = 0
  - br_true = 0
  - op_illegal = 0
  - counter = 0
  - in_ready = 1 from the first cycle after rst_n deasserts.
  - Any in-flight operation is discarded and no result is produced.
- Single-cycle ops: accept at edge N, out_valid = 1 after edge N+1's setup, i.e. visible in cycle N+1.
- Shift with shamt k ≥ 1: out_valid = 1 in cycle N+1+k. Maximum latency is 32 for shamt 31.
- Shift by 0: same latency as single-cycle ops, result = src_a.
- Throughput: one single-cycle op per cycle when out_ready is held high.
- Back-pressure: result, br_true and op_illegal do not change while out_valid && !out_ready.
- All outputs are registered except in_ready. in_ready is combinational from state and out_ready, and has no path from in_valid.

## Test plan
- Reset, then ADD with src_a = 0x7FFFFFFF, src_b = 1, out_ready = 1 → out_valid in cycle N+1, result = 0x80000000, br_true = 0.
- SRA with src_a = 0x80000000, src_b = 31 → out_valid exactly 32 cycles after accept, result = 0xFFFFFFFF. in_ready = 0 throughout SHIFT.
- BLT with src_a = 0xFFFFFFFF, src_b = 1 → br_true = 1, result = 0xFFFFFFFE. BGE on the same operands → br_true = 0. SLT on the same operands → result = 1.
- Streaming XOR, SUB, LUI with out_ready = 1 → one result per cycle in order (0x5^0x3 = 0x6; 5-7 = 0xFFFFFFFE; LUI src_b = 0x12345000 → 0x12345000). Then hold out_ready = 0 for 3 cycles → result stable and in_ready = 0.
- Opcode 1111 → result = 0, op_illegal = 1. The next legal op clears op_illegal.
- SLL with shamt 10 and rst_n pulsed low at the 4th shift cycle → all outputs are at reset values immediately. No out_valid occurs, and the next ADD completes normally.
